// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXI-stream frame generator: state encoding and
// default widths, also used by benches that check generated frames.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_GAP_WIDTH  = 4;

endpackage

// File: rtl/axis_frame_gen_ctr.sv
// Loadable down-counter with zero and one flags; saturates at zero.
module axis_frame_gen_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == W'(1));

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-stream frame source: runs of whole frames with incrementing payload,
// optional inter-frame gap, bad-frame marking on tuser and stop-after-frame.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [CNT_WIDTH-1:0]  frame_count,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic                  mark_bad,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
    logic                  r_tvalid, w_tvalid_nxt;
    logic                  r_tlast, w_tlast_nxt;
    logic                  r_tuser, w_tuser_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [CNT_WIDTH-1:0]  r_frames_sent, w_frames_sent_nxt;
    logic                  r_stop_pending, w_stop_pending_nxt;
    logic [LEN_WIDTH-1:0]  r_len_m1, w_len_m1_nxt;
    logic [CNT_WIDTH-1:0]  r_count, w_count_nxt;
    logic [GAP_WIDTH-1:0]  r_gap, w_gap_nxt;
    logic                  r_mark_bad, w_mark_bad_nxt;

    logic                  w_hs;
    logic [LEN_WIDTH-1:0]  w_len_m1_in;
    logic [CNT_WIDTH-1:0]  w_sent_inc;
    logic                  w_run_over;
    logic                  w_beat_load, w_beat_dec, w_beat_zero, w_beat_one;
    logic [LEN_WIDTH-1:0]  w_beat_ld_val;
    logic                  w_gap_load, w_gap_dec, w_gap_zero, w_gap_one;

    // Beat counter holds the number of beats still to follow the presented one.
    axis_frame_gen_ctr #(.W(LEN_WIDTH)) u_beat_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_beat_load),
        .i_load_val (w_beat_ld_val),
        .i_dec      (w_beat_dec),
        .o_zero     (w_beat_zero),
        .o_one      (w_beat_one)
    );

    axis_frame_gen_ctr #(.W(GAP_WIDTH)) u_gap_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (r_gap),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero),
        .o_one      (w_gap_one)
    );

    assign w_hs        = r_tvalid & output_axis_tready;
    assign w_len_m1_in = (frame_len == '0) ? '0 : frame_len - 1'b1;
    assign w_sent_inc  = r_frames_sent + 1'b1;
    assign w_run_over  = ((r_count != '0) && (w_sent_inc == r_count)) || r_stop_pending || stop;

    always_comb begin
        w_state_nxt        = r_state;
        w_tdata_nxt        = r_tdata;
        w_tvalid_nxt       = r_tvalid;
        w_tlast_nxt        = r_tlast;
        w_tuser_nxt        = r_tuser;
        w_busy_nxt         = r_busy;
        w_done_nxt         = 1'b0;
        w_frames_sent_nxt  = r_frames_sent;
        w_stop_pending_nxt = r_stop_pending;
        w_len_m1_nxt       = r_len_m1;
        w_count_nxt        = r_count;
        w_gap_nxt          = r_gap;
        w_mark_bad_nxt     = r_mark_bad;
        w_beat_load        = 1'b0;
        w_beat_ld_val      = r_len_m1;
        w_beat_dec         = 1'b0;
        w_gap_load         = 1'b0;
        w_gap_dec          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_len_m1_nxt       = w_len_m1_in;
                    w_count_nxt        = frame_count;
                    w_gap_nxt          = gap_cycles;
                    w_mark_bad_nxt     = mark_bad;
                    w_frames_sent_nxt  = '0;
                    w_tdata_nxt        = seed;
                    w_beat_load        = 1'b1;
                    w_beat_ld_val      = w_len_m1_in;
                    w_tlast_nxt        = (w_len_m1_in == '0);
                    w_tuser_nxt        = (w_len_m1_in == '0) & mark_bad;
                    w_tvalid_nxt       = 1'b1;
                    w_busy_nxt         = 1'b1;
                    w_stop_pending_nxt = stop;
                    w_state_nxt        = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stop) w_stop_pending_nxt = 1'b1;
                if (w_hs) begin
                    w_tdata_nxt = r_tdata + 1'b1;
                    if (w_beat_zero) begin
                        w_frames_sent_nxt = w_sent_inc;
                        if (w_run_over) begin
                            w_state_nxt        = ST_IDLE;
                            w_tvalid_nxt       = 1'b0;
                            w_tlast_nxt        = 1'b0;
                            w_tuser_nxt        = 1'b0;
                            w_busy_nxt         = 1'b0;
                            w_done_nxt         = 1'b1;
                            w_stop_pending_nxt = 1'b0;
                        end else begin
                            w_beat_load = 1'b1;
                            w_tlast_nxt = (r_len_m1 == '0);
                            w_tuser_nxt = (r_len_m1 == '0) & r_mark_bad;
                            if (r_gap != '0) begin
                                w_state_nxt  = ST_GAP;
                                w_tvalid_nxt = 1'b0;
                                w_gap_load   = 1'b1;
                            end
                        end
                    end else begin
                        w_beat_dec  = 1'b1;
                        w_tlast_nxt = w_beat_one;
                        w_tuser_nxt = w_beat_one & r_mark_bad;
                    end
                end
            end
            ST_GAP: begin
                // A stop seen during the gap ends the run before the next frame starts.
                if (stop || r_stop_pending) begin
                    w_state_nxt        = ST_IDLE;
                    w_tlast_nxt        = 1'b0;
                    w_tuser_nxt        = 1'b0;
                    w_busy_nxt         = 1'b0;
                    w_done_nxt         = 1'b1;
                    w_stop_pending_nxt = 1'b0;
                end else if (w_gap_one || w_gap_zero) begin
                    w_state_nxt  = ST_SEND;
                    w_tvalid_nxt = 1'b1;
                    w_gap_dec    = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_tuser        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_frames_sent  <= '0;
            r_stop_pending <= 1'b0;
            r_len_m1       <= '0;
            r_count        <= '0;
            r_gap          <= '0;
            r_mark_bad     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tdata        <= w_tdata_nxt;
            r_tvalid       <= w_tvalid_nxt;
            r_tlast        <= w_tlast_nxt;
            r_tuser        <= w_tuser_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_frames_sent  <= w_frames_sent_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_len_m1       <= w_len_m1_nxt;
            r_count        <= w_count_nxt;
            r_gap          <= w_gap_nxt;
            r_mark_bad     <= w_mark_bad_nxt;
        end
    end

    assign output_axis_tdata  = r_tdata;
    assign output_axis_tvalid = r_tvalid;
    assign output_axis_tlast  = r_tlast;
    assign output_axis_tuser  = r_tuser;
    assign busy               = r_busy;
    assign done               = r_done;
    assign frames_sent        = r_frames_sent;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: table-driven runs plus randomized runs, each checked
// against a frame-level model, and hand sequences for reset and stop corners.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [7:0]  frame_len;
    logic [15:0] frame_count;
    logic [3:0]  gap_cycles;
    logic        mark_bad;
    logic [7:0]  seed;
    logic [7:0]  tdata;
    logic        tvalid, tready, tlast, tuser;
    logic        busy, done;
    logic [15:0] frames_sent;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int len; int cnt; int gap; int mark; int seed; int rmode;
        int stop_beat; int stop_start;
        int exp_frames; int exp_beats; int exp_last;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    axis_frame_gen dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .stop               (stop),
        .frame_len          (frame_len),
        .frame_count        (frame_count),
        .gap_cycles         (gap_cycles),
        .mark_bad           (mark_bad),
        .seed               (seed),
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .output_axis_tuser  (tuser),
        .busy               (busy),
        .done               (done),
        .frames_sent        (frames_sent)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs one configuration to completion, checking protocol every cycle and
    // the collected beats against the frame model.
    task automatic run_vec(input vec_t v, output int fs_o, output int nb_o, output int last_o);
        int le, nfr, ns, beats, gcnt, r;
        bit in_frame, prev_stall, gtrack, seen_done;
        logic [7:0] pd;
        logic pl, pu;
        logic [7:0] gd[$];
        logic gl[$], gu[$];
        int gaps[$];
        le = (v.len == 0) ? 1 : v.len;
        nfr = v.cnt;
        if (v.stop_beat >= 0) begin
            ns = v.stop_beat / le + 1;
            if (nfr == 0 || ns < nfr) nfr = ns;
        end
        if (v.stop_start != 0) nfr = 1;
        beats = 0; gcnt = 0; in_frame = 0; prev_stall = 0; gtrack = 0; seen_done = 0;
        pd = '0; pl = 1'b0; pu = 1'b0;

        frame_len   = 8'(v.len);
        frame_count = 16'(v.cnt);
        gap_cycles  = 4'(v.gap);
        mark_bad    = v.mark[0];
        seed        = 8'(v.seed);
        start       = 1'b1;
        stop        = v.stop_start[0];
        tready      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("latency_tvalid", tvalid, 1);
        chk("busy_after_start", busy, 1);

        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (prev_stall) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, pd);
                chk("stall_tlast", tlast, pl);
                chk("stall_tuser", tuser, pu);
            end
            if (in_frame) chk("midframe_tvalid", tvalid, 1);
            if (tvalid && tuser) chk("tuser_only_on_tlast", tlast, 1);
            if (gtrack) begin
                if (tvalid) begin
                    gaps.push_back(gcnt);
                    gtrack = 0;
                end else begin
                    gcnt++;
                end
            end
            if (v.rmode == 0) r = 1;
            else if (v.rmode == 1) r = ((c % 2) == 0) ? 1 : 0;
            else r = ($urandom_range(0, 3) != 0) ? 1 : 0;
            stop = (v.stop_beat >= 0 && tvalid && beats == v.stop_beat);
            if (c == 2) begin
                start       = 1'b1;
                seed        = 8'($urandom);
                frame_len   = 8'($urandom);
                frame_count = 16'($urandom);
                gap_cycles  = 4'($urandom);
                mark_bad    = ~v.mark[0];
            end else begin
                start = 1'b0;
            end
            tready = r[0];
            if (tvalid && r != 0) begin
                gd.push_back(tdata);
                gl.push_back(tlast);
                gu.push_back(tuser);
                beats++;
                in_frame = !tlast;
                if (tlast) begin
                    gtrack = 1;
                    gcnt = 0;
                end
            end
            prev_stall = tvalid && (r == 0);
            pd = tdata; pl = tlast; pu = tuser;
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;

        if (!seen_done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: done not seen, beats=%0d expected_frames=%0d", beats, nfr);
        end else begin
            chk("done_busy_low", busy, 0);
            chk("done_tvalid_low", tvalid, 0);
            chk("frames_sent_model", frames_sent, nfr);
            fs_o = int'(frames_sent);
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("frames_sent_hold", frames_sent, nfr);
        end
        if (!seen_done) fs_o = int'(frames_sent);

        chk("beat_count_model", gd.size(), nfr * le);
        for (int i = 0; i < gd.size() && i < nfr * le; i++) begin
            logic [7:0] ed;
            logic el;
            ed = 8'(v.seed + i);
            el = ((i % le) == le - 1);
            chk("beat_tdata", gd[i], ed);
            chk("beat_tlast", gl[i], el);
            chk("beat_tuser", gu[i], el & v.mark[0]);
        end
        chk("gap_count", gaps.size(), nfr - 1);
        foreach (gaps[i]) chk("gap_len", gaps[i], v.gap);
        nb_o   = gd.size();
        last_o = (gd.size() > 0) ? int'(gd[gd.size() - 1]) : -1;
    endtask

    initial begin
        int fs, nb, lst;
        vec_t rv;

        //            len cnt gap mk seed  rm stopb ss  frm beats last
        tbl[0] = '{4, 2, 0, 0, 'h10, 0, -1, 0, 2, 8,  'h17};
        tbl[1] = '{4, 2, 0, 0, 'h10, 1, -1, 0, 2, 8,  'h17};
        tbl[2] = '{3, 2, 2, 1, 'h40, 0, -1, 0, 2, 6,  'h45};
        tbl[3] = '{5, 0, 0, 0, 'h00, 0, 11, 0, 3, 15, 'h0E};
        tbl[4] = '{4, 1, 0, 0, 'hFE, 0, -1, 0, 1, 4,  'h01};
        tbl[5] = '{0, 3, 1, 0, 'h20, 0, -1, 0, 3, 3,  'h22};
        tbl[6] = '{1, 1, 0, 1, 'h33, 0, -1, 0, 1, 1,  'h33};
        tbl[7] = '{3, 0, 0, 0, 'h50, 0, -1, 1, 1, 3,  'h52};
        tbl[8] = '{2, 3, 3, 0, 'h80, 2, -1, 0, 3, 6,  'h85};

        rst = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
        frame_len = '0; frame_count = '0; gap_cycles = '0; mark_bad = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tlast", tlast, 0);
        chk("reset_tuser", tuser, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_frames_sent", frames_sent, 0);
        rst = 1'b1;
        @(negedge clk);

        // A stop in IDLE must not leave a pending stop behind.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], fs, nb, lst);
            chk("tbl_frames_sent", fs, tbl[i].exp_frames);
            chk("tbl_beats", nb, tbl[i].exp_beats);
            chk("tbl_last_tdata", lst, tbl[i].exp_last);
            @(negedge clk);
        end

        // Stop arriving while the generator sits in the inter-frame gap.
        frame_len = 8'd2; frame_count = 16'd0; gap_cycles = 4'd3; mark_bad = 1'b0;
        seed = 8'h60; tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gapstop_beat0", tdata, 8'h60);
        @(negedge clk);
        chk("gapstop_tlast", tlast, 1);
        @(negedge clk);
        chk("gapstop_in_gap", tvalid, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("gapstop_done", done, 1);
        chk("gapstop_busy", busy, 0);
        chk("gapstop_frames", frames_sent, 1);
        @(negedge clk);
        chk("gapstop_no_frame", tvalid, 0);
        chk("gapstop_done_clear", done, 0);

        // Reset in the middle of the second frame of a continuous run.
        frame_len = 8'd6; frame_count = 16'd0; gap_cycles = 4'd0; seed = 8'h90;
        tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("rstmid_pre_tdata", tdata, 8'h97);
        chk("rstmid_pre_frames", frames_sent, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstmid_tvalid", tvalid, 0);
        chk("rstmid_tlast", tlast, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_frames", frames_sent, 0);
        chk("rstmid_done", done, 0);
        @(negedge clk);
        rv = '{2, 1, 0, 0, 'hA0, 0, -1, 0, 1, 2, 'hA1};
        run_vec(rv, fs, nb, lst);
        chk("rstmid_resume_last", lst, 'hA1);

        for (int k = 0; k < 20; k++) begin
            int le;
            rv.len   = $urandom_range(0, 7);
            rv.cnt   = $urandom_range(0, 4);
            rv.gap   = $urandom_range(0, 3);
            rv.mark  = $urandom_range(0, 1);
            rv.seed  = $urandom_range(0, 255);
            rv.rmode = 2;
            rv.stop_start = ($urandom_range(0, 9) == 0) ? 1 : 0;
            le = (rv.len == 0) ? 1 : rv.len;
            if (rv.cnt == 0) rv.stop_beat = $urandom_range(0, 3 * le - 1);
            else rv.stop_beat = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4 * le) : -1;
            rv.exp_frames = 0; rv.exp_beats = 0; rv.exp_last = 0;
            run_vec(rv, fs, nb, lst);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
AXI-stream frame transmitter: the source that drives the input side of the team's frame FIFOs. On a start command it emits a run of frames with programmable length, incrementing payload, optional inter-frame gap and optional bad-frame marking on tuser. Frames are always sent whole, ending with tlast, because downstream FIFOs commit or drop only on tlast. Used as a traffic source in FIFO test harnesses and loopback paths.

Parameters:
DATA_WIDTH, 8, tdata width
LEN_WIDTH, 8, width of frame length (beats per frame)
CNT_WIDTH, 16, width of frame count and frames_sent
GAP_WIDTH, 4, width of inter-frame idle cycle count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  one-cycle start pulse; ignored while busy
stop  input  1  request stop after current frame; sampled every cycle
frame_len  input  LEN_WIDTH  beats per frame, latched at start; 0 treated as 1
frame_count  input  CNT_WIDTH  frames per run, latched at start; 0 = continuous until stop
gap_cycles  input  GAP_WIDTH  idle cycles between frames, latched at start
mark_bad  input  1  latched at start; when 1, tuser=1 on last beat of every frame
seed  input  DATA_WIDTH  first tdata value of run, latched at start
output_axis_tdata  output  DATA_WIDTH  payload
output_axis_tvalid  output  1  beat valid
output_axis_tready  input  1  downstream ready
output_axis_tlast  output  1  last beat of frame
output_axis_tuser  output  1  bad-frame flag, only ever 1 on a tlast beat
busy  output  1  high from accepted start until run ends
done  output  1  one-cycle pulse when run ends
frames_sent  output  CNT_WIDTH  frames completed in current/last run

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; tvalid, tlast, tuser, busy, done = 0; tdata = 0; frames_sent = 0; stop_pending = 0; all latched config cleared. Reset mid-frame abandons the frame: tvalid low the following cycle, no tlast issued.
- All outputs registered. Handshake = tvalid & tready on a rising edge.
- States: IDLE, SEND, GAP.
- IDLE: start=1 -> latch config, frames_sent=0, tdata=seed, beat_cnt=0, tlast=(len==1), tuser=(len==1)&mark_bad, busy=1, go SEND. tvalid first high the cycle after start (latency 1).
- SEND: tvalid=1. Without handshake tdata/tlast/tuser hold stable (AXIS rule); tvalid never drops mid-frame.
- Per handshake: tdata increments by 1 modulo 2^DATA_WIDTH (continues across frames; seed used only at start); beat_cnt++; tlast=1 exactly when beat_cnt==len-1; tuser=tlast & mark_bad.
- Handshake on tlast beat: frames_sent++ (wraps mod 2^CNT_WIDTH). Then:
  - (frame_count!=0 and frames_sent+1==frame_count) or stop_pending or stop this cycle -> IDLE, tvalid=0, busy=0, done pulse next cycle, stop_pending=0.
  - else gap_cycles==0 -> stay SEND, next frame first beat valid in next cycle (back-to-back, no bubble).
  - else -> GAP, tvalid=0, gap counter loaded.
- GAP: count down gap_cycles cycles with tvalid=0, then SEND with tvalid=1. If stop or stop_pending during GAP -> IDLE next cycle, done pulse, no further frame.
- stop in IDLE: no effect. stop mid-frame: sets stop_pending; frame completes normally.
- start while busy ignored; config inputs ignored except at accepted start.
- Simultaneous start and stop in IDLE: start accepted, stop_pending set, exactly one frame sent.
- frame_count=1, len=1: one beat with tlast=1, then done.

Decomposition:
- Shared package axis_frame_gen_pkg: state encoding localparams (IDLE, SEND, GAP) and shared defaults (DATA_WIDTH, LEN_WIDTH, CNT_WIDTH). Reusable by the bench's frame checker.
- One natural sub-module: axis_frame_gen_ctr, a loadable down-counter with zero flag, instanced for beat counting and gap timing. FSM and output registers stay in the top.

Test Plan:
- start, seed=0x10, len=4, count=2, gap=0, tready=1 -> 8 consecutive beats 0x10..0x17, tlast on 0x13 and 0x17, tuser=0, done pulse, frames_sent=2.
- Same config, tready toggled 1/0 every cycle -> identical beat sequence; tdata/tlast held stable on every stalled cycle; tvalid never drops mid-frame.
- len=3, count=2, gap=2, mark_bad=1 -> exactly 2 tvalid-low cycles between frames; tuser=1 only on the two tlast beats.
- count=0 (continuous), len=5, stop asserted at the 2nd beat of frame 3 -> frame 3 completes (5 beats), no frame 4, frames_sent=3, done pulse.
- seed=0xFE, len=4 -> tdata 0xFE,0xFF,0x00,0x01 (wrap); frame_len=0 -> single-beat frames with tlast=1.
- rst=0 during beat 2 of a len=6 frame -> next cycle tvalid=0, busy=0, frames_sent=0; start after reset resumes from new seed.
